// File: rtl/adc_stream_arbiter_pkg.sv
// adc_stream_arbiter shared types: FSM states, word width, header layout.
// Header helper builds the optional per-burst source header beat.
package adc_stream_arbiter_pkg;

  localparam int ADC_WORD_W = 128;
  localparam logic [15:0] ARB_HDR_MAGIC = 16'hADC0;

  localparam int HDR_MAGIC_LSB = 112;
  localparam int HDR_CH_LSB    = 104;
  localparam int HDR_LEN_LSB   = 96;
  localparam int HDR_SEQ_LSB   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_BURST = 2'd2
  } arb_state_t;

  function automatic logic [ADC_WORD_W-1:0] arb_hdr(
    input logic [2:0]  ch,
    input logic [7:0]  len,
    input logic [31:0] seq
  );
    logic [ADC_WORD_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB+:16] = ARB_HDR_MAGIC;
    h[HDR_CH_LSB+:8]     = {5'd0, ch};
    h[HDR_LEN_LSB+:8]    = len;
    h[HDR_SEQ_LSB+:32]   = seq;
    return h;
  endfunction

endpackage

// File: rtl/adc_stream_arbiter_pick.sv
// Round-robin pick: first set req bit searching upward from last_grant+1.
// Ports: req, last_grant in; grant (index), found out. Combinational.
module rr_arbiter_pick
  import adc_stream_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [2:0]        last_grant,
  output logic [2:0]        grant,
  output logic              found
);

  int idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(last_grant) + 1 + k) % NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/adc_stream_arbiter.sv
// Round-robin burst scheduler sharing one 128-bit AXIS path among NUM_CH
// channel streams. Optional header beat per burst: ADC_ARB_HEADER_EN.
// Ports: pl_clk, rst (async, low); ch_enable; s_axis_* per channel;
// m_axis_* merged output with tlast on final data beat; grant_ch; busy.
module adc_stream_arbiter
  import adc_stream_arbiter_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BURST_LEN = 16
) (
  input  logic                         pl_clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH*ADC_WORD_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  output logic [NUM_CH-1:0]            s_axis_tready,
  output logic [ADC_WORD_W-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [2:0]                   grant_ch,
  output logic                         busy
);

  arb_state_t state, state_nx;

  logic [2:0]  last_grant;
  logic [2:0]  pick_ch;
  logic        pick_ok;
  logic [7:0]  beat_cnt;
  logic [31:0] seq_cnt;
  logic        beat_fire;
  logic        last_beat;

  logic [NUM_CH-1:0]     req;
  logic [ADC_WORD_W-1:0] sel_data;
  logic                  sel_valid;

`ifdef ADC_ARB_HEADER_EN
  logic [ADC_WORD_W-1:0] hdr_q;
`endif

  assign req = ch_enable & s_axis_tvalid;

  rr_arbiter_pick #(
    .NUM_CH(NUM_CH)
  ) u_pick (
    .req       (req),
    .last_grant(last_grant),
    .grant     (pick_ch),
    .found     (pick_ok)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_ch == 3'(i)) begin
        sel_data  = s_axis_tdata[i*ADC_WORD_W+:ADC_WORD_W];
        sel_valid = s_axis_tvalid[i];
      end
    end
  end

  assign last_beat = (beat_cnt == 8'(BURST_LEN-1));

  always_comb begin
    state_nx      = state;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    busy          = 1'b0;
    beat_fire     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_ok) begin
`ifdef ADC_ARB_HEADER_EN
          state_nx = ST_HDR;
`else
          state_nx = ST_BURST;
`endif
        end
      end
`ifdef ADC_ARB_HEADER_EN
      ST_HDR: begin
        busy          = 1'b1;
        m_axis_tdata  = hdr_q;
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_nx = ST_BURST;
      end
`endif
      ST_BURST: begin
        busy          = 1'b1;
        m_axis_tdata  = sel_data;
        m_axis_tvalid = sel_valid;
        m_axis_tlast  = last_beat;
        for (int i = 0; i < NUM_CH; i++)
          s_axis_tready[i] = (grant_ch == 3'(i)) && m_axis_tready;
        beat_fire = sel_valid && m_axis_tready;
        if (beat_fire && last_beat) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      grant_ch   <= '0;
      last_grant <= 3'(NUM_CH-1);
      beat_cnt   <= '0;
      seq_cnt    <= '0;
`ifdef ADC_ARB_HEADER_EN
      hdr_q      <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (pick_ok) begin
            grant_ch   <= pick_ch;
            last_grant <= pick_ch;
            beat_cnt   <= '0;
`ifdef ADC_ARB_HEADER_EN
            hdr_q <= arb_hdr(pick_ch, 8'(BURST_LEN), seq_cnt);
`endif
          end
        end
`ifdef ADC_ARB_HEADER_EN
        ST_HDR: ;
`endif
        ST_BURST: begin
          if (beat_fire) begin
            if (last_beat) begin
              beat_cnt <= '0;
              seq_cnt  <= seq_cnt + 32'd1;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: begin
          // Illegal encoding: fall back to reset values.
          grant_ch   <= '0;
          last_grant <= 3'(NUM_CH-1);
          beat_cnt   <= '0;
          seq_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_stream_arbiter.sv
// Directed bench for adc_stream_arbiter, NUM_CH=4, BURST_LEN=4.
// Header checks compile in when ADC_ARB_HEADER_EN is defined.
module tb_adc_stream_arbiter;

  localparam int NCH = 4;
  localparam int BL  = 4;

  logic           pl_clk;
  logic           rst;
  logic [NCH-1:0] ch_enable;
  logic [NCH*128-1:0] s_tdata;
  logic [NCH-1:0] s_tvalid;
  logic [NCH-1:0] s_tready;
  logic [127:0]   m_tdata;
  logic           m_tvalid;
  logic           m_tready;
  logic           m_tlast;
  logic [2:0]     grant_ch;
  logic           busy;

  int n_cmp;
  int n_mis;
  int nb[NCH];
  int expn[NCH];
  logic [31:0] seq_m;

  adc_stream_arbiter #(
    .NUM_CH   (NCH),
    .BURST_LEN(BL)
  ) dut (
    .pl_clk       (pl_clk),
    .rst          (rst),
    .ch_enable    (ch_enable),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .grant_ch     (grant_ch),
    .busy         (busy)
  );

  initial pl_clk = 1'b0;
  always #5 pl_clk = ~pl_clk;

  function automatic logic [127:0] mk(input int c, input int n);
    return {16'hDA7A, 16'(c), 32'(n), ~32'(n), 32'h1234_5678 ^ 32'(c)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive_data();
    for (int c = 0; c < NCH; c++)
      s_tdata[c*128+:128] = mk(c, nb[c]);
  endtask

  // Upstream FIFO model: pops a word on each handshake.
  task automatic tick();
    logic [NCH-1:0] acc;
    acc = s_tready & s_tvalid;
    @(posedge pl_clk);
    #1;
    for (int c = 0; c < NCH; c++)
      if (acc[c]) nb[c]++;
    drive_data();
  endtask

  task automatic burst(input int ch, input bit stall);
    int  k;
    int  cyc;
    bit  rdy;
    logic [127:0] sr;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_valid", m_tvalid, 0);
    chk("idle_sready", s_tready, 0);
    tick();
    chk("grant_ch", grant_ch, ch);
    chk("busy", busy, 1);
`ifdef ADC_ARB_HEADER_EN
    m_tready = 1'b1;
    #1;
    chk("hdr_valid", m_tvalid, 1);
    chk("hdr_last", m_tlast, 0);
    chk("hdr_data", m_tdata,
        {16'hADC0, 8'(ch), 8'(BL), seq_m, 64'd0});
    tick();
`endif
    k = 0;
    cyc = 0;
    while (k < BL && cyc < 64) begin
      rdy = stall ? cyc[0] : 1'b1;
      m_tready = rdy;
      #1;
      sr = rdy ? 128'(1 << ch) : 128'd0;
      chk("beat_valid", m_tvalid, 1);
      chk("beat_data", m_tdata, mk(ch, expn[ch] + k));
      chk("beat_last", m_tlast, 128'(k == BL-1));
      chk("beat_sready", s_tready, sr);
      if (rdy) k++;
      tick();
      cyc++;
    end
    chk("beat_count", k, BL);
    expn[ch] += BL;
    seq_m++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    seq_m = 0;
    for (int c = 0; c < NCH; c++) begin
      nb[c] = 0;
      expn[c] = 0;
    end
    rst = 1'b0;
    ch_enable = '1;
    s_tvalid = '0;
    m_tready = 1'b1;
    drive_data();
    #3;
    chk("rst_sready", s_tready, 0);
    chk("rst_valid", m_tvalid, 0);
    chk("rst_data", m_tdata, 0);
    chk("rst_last", m_tlast, 0);
    chk("rst_grant", grant_ch, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge pl_clk);
    #2;
    rst = 1'b1;
    tick();

    // ch0 alone
    s_tvalid = 4'b0001;
    burst(0, 1'b0);

    // all channels: rotation continues 1,2,3,0
    s_tvalid = 4'b1111;
    burst(1, 1'b0);
    burst(2, 1'b0);
    burst(3, 1'b0);
    burst(0, 1'b0);

    // ch1 disabled, ch3 idle
    ch_enable = 4'b1101;
    s_tvalid  = 4'b0111;
    burst(2, 1'b0);
    burst(0, 1'b0);
    burst(2, 1'b0);
    burst(0, 1'b0);

    // downstream stalls every other cycle
    ch_enable = 4'b1111;
    s_tvalid  = 4'b1111;
    burst(1, 1'b1);

    // ch2 twice, header sequence advances
    s_tvalid = 4'b0100;
    burst(2, 1'b0);
    burst(2, 1'b0);

    // reset after two beats of a ch3 burst
    s_tvalid = 4'b1111;
    #1;
    tick();
    chk("mid_grant", grant_ch, 3);
    m_tready = 1'b1;
`ifdef ADC_ARB_HEADER_EN
    tick();
`endif
    tick();
    tick();
    chk("mid_nb3", nb[3], expn[3] + 2);
    rst = 1'b0;
    #1;
    chk("mid_sready", s_tready, 0);
    chk("mid_valid", m_tvalid, 0);
    chk("mid_data", m_tdata, 0);
    chk("mid_last", m_tlast, 0);
    chk("mid_grant0", grant_ch, 0);
    chk("mid_busy", busy, 0);
    seq_m = 0;
    #1;
    rst = 1'b1;
    burst(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
